hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Next-generation hazard unit for the RV32I pipeline (F/D/E/M/W). It generalises the combinational forward/stall/flush logic to handle a variable-latency multi-cycle execute unit (MUL/DIV class).
- A per-register pending-write scoreboard plus a small FSM track the single in-flight multi-cycle operation.
- Forwarding, stalls and flushes are computed against both the normal pipeline and the scoreboard.
- Saturating performance counters record stall and flush cycles.

Parameters:
NREG, 32, number of architectural registers (x0 hard-wired zero)
RA_W, 5, register address width, equal to $clog2(NREG)
CNT_W, 16, width of each saturating performance counter
BPU_EN, 1, 1 = branch prediction unit present (flush on mispredict); 0 = flush on every taken branch/jump

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
no_fwd_i  in  1  1 = forwarding disabled; RAW hazards resolved by stalling
rs1d_i, rs2d_i, rdd_i  in  RA_W each  decode-stage source and destination registers
mcd_i  in  1  decode instruction is a multi-cycle op
rs1e_i, rs2e_i, rde_i  in  RA_W each  execute-stage registers
regwritee_i, loade_i  in  1 each  execute writes a register / is a load
mc_issue_i  in  1  multi-cycle op in E accepted by the MC unit this cycle
mc_done_i  in  1  MC unit writes its result this cycle (dedicated write port)
rdm_i, rdw_i  in  RA_W each  memory / writeback destination registers
regwritem_i, regwritew_i  in  1 each  memory / writeback write enables
branchd_i  in  1  decode instruction is a branch or jump
pcsrce_i, pred_e_i  in  1 each  resolved taken / predicted taken for the E instruction
forwardae_o, forwardbe_o  out  2 each  00 register file, 10 from M, 01 from W
stallf_o, stalld_o, flushd_o, flushe_o  out  1 each  pipeline controls
mc_busy_o  out  1  multi-cycle op in flight
pending_o  out  NREG  scoreboard bit vector
stall_cnt_o, flush_cnt_o  out  CNT_W each  saturating counters

Behaviour:
Reset values:
- All registers clear asynchronously on rst_i: FSM=IDLE, pending_o=0, mc_rd=0, counters=0.
- While rst_i is high, all outputs are 0.

FSM:
- IDLE → BUSY on mc_issue_i; latch mc_rd=rde_i and set pending[rde_i] if rde_i≠0.
- BUSY → IDLE on mc_done_i; clear pending[mc_rd].
- BUSY with mc_done_i & mc_issue_i in the same cycle: stay BUSY, clear the old bit, set the new bit. If the old and new rd are equal, the bit stays set.
- mc_issue_i while BUSY without mc_done_i is a protocol error. An SVA assertion checks it; state is unchanged.
- mc_done_i in IDLE is ignored.
- mc_busy_o = (state==BUSY).

Forwarding (combinational, only when no_fwd_i=0):
- For rsXe≠0: match against rdm_i with regwritem_i gives 10. Otherwise match against rdw_i with regwritew_i gives 01. Otherwise 00. M has priority.
- When no_fwd_i=1 the output is always 00.

Stall conditions (decode):
- lw_stall = loade_i & rde_i≠0 & (rs1d_i==rde_i | rs2d_i==rde_i).
- sb_stall = pending[rs1d_i] | pending[rs2d_i] | (rdd_i≠0 & pending[rdd_i]), the last term covering WAW. The scoreboard bit cleared by mc_done_i in the same cycle still counts as pending, so the result is read next cycle.
- mc_stall = mcd_i & (BUSY & ~mc_done_i).
- nf_stall (no_fwd_i=1 only): rsXd≠0 matching rde_i & regwritee_i or rdm_i & regwritem_i.
- x0 never causes a stall.

Pipeline controls:
- hz = lw_stall | sb_stall | mc_stall | nf_stall.
- stalld_o = hz.
- stallf_o = hz | (BPU_EN ? 0 : branchd_i).
- redirect = BPU_EN ? (pcsrce_i ^ pred_e_i) : pcsrce_i.
- flushd_o = redirect | (BPU_EN ? 0 : branchd_i).
- flushe_o = redirect | hz.
- Redirect with hz in the same cycle: both flushes assert and stalls still assert. The younger instructions are discarded, so this is harmless.
- An MC op already issued is older than the redirecting branch and is never cancelled.

Counters:
- stall_cnt increments on each cycle with stalld_o=1; flush_cnt increments on each cycle with redirect=1.
- Both saturate at all-ones (no wrap).

Decomposition:
- Package hazard_pkg holds: fwd_sel_e enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10), mc_state_e {MC_IDLE, MC_BUSY}, and the RA_W/NREG defaults.
- One sub-module, sat_counter (CNT_W, inc, async reset), instantiated twice.
- The scoreboard and FSM stay in the top level.

Test Plan:
- Forwarding: rs1e=5, rdm=5 with regwritem=1, rdw=5 with regwritew=1 → forwardae=10. Drop regwritem → 01. rs1e=0 → 00.
- Load-use: loade=1, rde=7, rs2d=7 → stallf=stalld=flushe=1 for exactly 1 cycle; stall_cnt +1.
- MC scoreboard: issue with rde=9 → pending[9]=1, mc_busy=1. A dependent decode with rs1d=9 stalls until mc_done, is released the cycle after done, and pending[9] returns to 0.
- Back-to-back MC: in BUSY(rd=3), apply mc_done & mc_issue(rde=4) together → pending=bit4 only, FSM stays BUSY.
- Mispredict: BPU_EN=1, pcsrce=1, pred=0 → flushd=flushe=1 and flush_cnt +1. pcsrce=pred=1 → no flush. BPU_EN=0 with branchd=1 → stallf=1, flushd=1.
- Reset mid-operation: assert rst_i while BUSY with pending[12]=1 → pending=0, mc_busy=0, counters=0 immediately, without waiting for a clock edge. Counter saturation: force stall for 2^CNT_W+5 cycles → counter holds all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forwarding select codes, MC FSM states, register-file defaults.
// Types only; no timing and no flow control live here.
package hazard_pkg;

    localparam int NREG_DEF = 32;
    localparam int RA_W_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc_i high and sticks at all-ones.
// Latency: the count reflects inc_i one clock later; inc_i is never refused.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// RV32I hazard unit with a pending-write scoreboard for one in-flight multi-cycle op.
// Latency: forward/stall/flush are combinational; scoreboard and counters update on the next clock.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int CNT_W  = 16,
    parameter int BPU_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             no_fwd_i,
    input  logic [RA_W-1:0]  rs1d_i,
    input  logic [RA_W-1:0]  rs2d_i,
    input  logic [RA_W-1:0]  rdd_i,
    input  logic             mcd_i,
    input  logic [RA_W-1:0]  rs1e_i,
    input  logic [RA_W-1:0]  rs2e_i,
    input  logic [RA_W-1:0]  rde_i,
    input  logic             regwritee_i,
    input  logic             loade_i,
    input  logic             mc_issue_i,
    input  logic             mc_done_i,
    input  logic [RA_W-1:0]  rdm_i,
    input  logic [RA_W-1:0]  rdw_i,
    input  logic             regwritem_i,
    input  logic             regwritew_i,
    input  logic             branchd_i,
    input  logic             pcsrce_i,
    input  logic             pred_e_i,
    output logic [1:0]       forwardae_o,
    output logic [1:0]       forwardbe_o,
    output logic             stallf_o,
    output logic             stalld_o,
    output logic             flushd_o,
    output logic             flushe_o,
    output logic             mc_busy_o,
    output logic [NREG-1:0]  pending_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam bit USE_BPU = (BPU_EN != 0);

    mc_state_e        state_q, state_d;
    logic [RA_W-1:0]  mc_rd_q, mc_rd_d;
    logic [NREG-1:0]  pending_q, pending_d;

    fwd_sel_e fwd_a, fwd_b;
    logic     lw_stall, sb_stall, mc_stall, nf_stall, hz;
    logic     redirect, branch_bubble;

    function automatic fwd_sel_e fwd_sel(
        input logic [RA_W-1:0] rs,
        input logic            no_fwd,
        input logic [RA_W-1:0] rdm,
        input logic            wem,
        input logic [RA_W-1:0] rdw,
        input logic            wew
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (!no_fwd && (rs != '0)) begin
            if (wem && (rs == rdm)) begin
                sel = FWD_M;
            end else if (wew && (rs == rdw)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    function automatic logic nf_dep(
        input logic [RA_W-1:0] rs,
        input logic [RA_W-1:0] rde,
        input logic            wee,
        input logic [RA_W-1:0] rdm,
        input logic            wem
    );
        return (rs != '0) && ((wee && (rs == rde)) || (wem && (rs == rdm)));
    endfunction

    // Same-cycle done+issue clears the old bit first so an equal rd stays set.
    always_comb begin
        state_d   = state_q;
        mc_rd_d   = mc_rd_q;
        pending_d = pending_q;
        case (state_q)
            MC_IDLE: begin
                if (mc_issue_i) begin
                    state_d = MC_BUSY;
                    mc_rd_d = rde_i;
                    if (rde_i != '0) begin
                        pending_d[rde_i] = 1'b1;
                    end
                end
            end
            MC_BUSY: begin
                if (mc_done_i) begin
                    pending_d[mc_rd_q] = 1'b0;
                    if (mc_issue_i) begin
                        mc_rd_d = rde_i;
                        if (rde_i != '0) begin
                            pending_d[rde_i] = 1'b1;
                        end
                    end else begin
                        state_d = MC_IDLE;
                    end
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= MC_IDLE;
            mc_rd_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            mc_rd_q   <= mc_rd_d;
            pending_q <= pending_d;
        end
    end

    mc_issue_while_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        !((state_q == MC_BUSY) && mc_issue_i && !mc_done_i));

    // The registered scoreboard is used, so a bit being cleared this cycle still stalls.
    always_comb begin
        fwd_a    = fwd_sel(rs1e_i, no_fwd_i, rdm_i, regwritem_i, rdw_i, regwritew_i);
        fwd_b    = fwd_sel(rs2e_i, no_fwd_i, rdm_i, regwritem_i, rdw_i, regwritew_i);
        lw_stall = loade_i && (rde_i != '0) && ((rs1d_i == rde_i) || (rs2d_i == rde_i));
        sb_stall = pending_q[rs1d_i] || pending_q[rs2d_i] || ((rdd_i != '0) && pending_q[rdd_i]);
        mc_stall = mcd_i && (state_q == MC_BUSY) && !mc_done_i;
        nf_stall = no_fwd_i && (nf_dep(rs1d_i, rde_i, regwritee_i, rdm_i, regwritem_i) ||
                                nf_dep(rs2d_i, rde_i, regwritee_i, rdm_i, regwritem_i));
        hz       = lw_stall || sb_stall || mc_stall || nf_stall;
        redirect      = USE_BPU ? (pcsrce_i ^ pred_e_i) : pcsrce_i;
        branch_bubble = USE_BPU ? 1'b0 : branchd_i;
    end

    assign forwardae_o = rst_i ? FWD_RF : fwd_a;
    assign forwardbe_o = rst_i ? FWD_RF : fwd_b;
    assign stalld_o    = !rst_i && hz;
    assign stallf_o    = !rst_i && (hz || branch_bubble);
    assign flushd_o    = !rst_i && (redirect || branch_bubble);
    assign flushe_o    = !rst_i && (redirect || hz);
    assign mc_busy_o   = (state_q == MC_BUSY);
    assign pending_o   = pending_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stalld_o),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (!rst_i && redirect),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one instance with branch prediction, one without, both on shared stimulus.
module tb_hazard_scoreboard;

    localparam int CNT_W = 16;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       no_fwd, mcd, regwritee, loade, mc_issue, mc_done;
    logic       regwritem, regwritew, branchd, pcsrce, pred_e;
    logic [4:0] rs1d, rs2d, rdd, rs1e, rs2e, rde, rdm, rdw;

    logic [1:0]       fwda_b, fwdb_b, fwda_n, fwdb_n;
    logic             stallf_b, stalld_b, flushd_b, flushe_b, busy_b;
    logic             stallf_n, stalld_n, flushd_n, flushe_n, busy_n;
    logic [31:0]      pend_b, pend_n;
    logic [CNT_W-1:0] scnt_b, fcnt_b, scnt_n, fcnt_n;

    int checks   = 0;
    int failures = 0;

    bit        m_busy   = 1'b0;
    bit [4:0]  m_rd     = '0;
    bit [31:0] m_pend   = '0;
    int        m_scnt   = 0;
    int        m_fcnt_b = 0;
    int        m_fcnt_n = 0;

    hazard_scoreboard #(.NREG(32), .RA_W(5), .CNT_W(CNT_W), .BPU_EN(1)) u_bpu (
        .clk_i(clk), .rst_i(rst), .no_fwd_i(no_fwd),
        .rs1d_i(rs1d), .rs2d_i(rs2d), .rdd_i(rdd), .mcd_i(mcd),
        .rs1e_i(rs1e), .rs2e_i(rs2e), .rde_i(rde),
        .regwritee_i(regwritee), .loade_i(loade),
        .mc_issue_i(mc_issue), .mc_done_i(mc_done),
        .rdm_i(rdm), .rdw_i(rdw), .regwritem_i(regwritem), .regwritew_i(regwritew),
        .branchd_i(branchd), .pcsrce_i(pcsrce), .pred_e_i(pred_e),
        .forwardae_o(fwda_b), .forwardbe_o(fwdb_b),
        .stallf_o(stallf_b), .stalld_o(stalld_b), .flushd_o(flushd_b), .flushe_o(flushe_b),
        .mc_busy_o(busy_b), .pending_o(pend_b),
        .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
    );

    hazard_scoreboard #(.NREG(32), .RA_W(5), .CNT_W(CNT_W), .BPU_EN(0)) u_nobpu (
        .clk_i(clk), .rst_i(rst), .no_fwd_i(no_fwd),
        .rs1d_i(rs1d), .rs2d_i(rs2d), .rdd_i(rdd), .mcd_i(mcd),
        .rs1e_i(rs1e), .rs2e_i(rs2e), .rde_i(rde),
        .regwritee_i(regwritee), .loade_i(loade),
        .mc_issue_i(mc_issue), .mc_done_i(mc_done),
        .rdm_i(rdm), .rdw_i(rdw), .regwritem_i(regwritem), .regwritew_i(regwritew),
        .branchd_i(branchd), .pcsrce_i(pcsrce), .pred_e_i(pred_e),
        .forwardae_o(fwda_n), .forwardbe_o(fwdb_n),
        .stallf_o(stallf_n), .stalld_o(stalld_n), .flushd_o(flushd_n), .flushe_o(flushe_n),
        .mc_busy_o(busy_n), .pending_o(pend_n),
        .stall_cnt_o(scnt_n), .flush_cnt_o(fcnt_n)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: reason about registers that are waiting on the MC unit, not about FSM encodings.
    function automatic bit waiting_on(input logic [4:0] r);
        return (r != 5'd0) && m_pend[r];
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (no_fwd || rs == 5'd0) return 2'b00;
        if (regwritem && rdm == rs) return 2'b10;
        if (regwritew && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_hz();
        bit load_use, sb, mc, nf;
        load_use = loade && rde != 5'd0 && (rs1d == rde || rs2d == rde);
        sb       = waiting_on(rs1d) || waiting_on(rs2d) || waiting_on(rdd);
        mc       = mcd && m_busy && !mc_done;
        nf       = no_fwd && ((rs1d != 0 && ((regwritee && rs1d == rde) || (regwritem && rs1d == rdm))) ||
                              (rs2d != 0 && ((regwritee && rs2d == rde) || (regwritem && rs2d == rdm))));
        return load_use || sb || mc || nf;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_rd     <= '0;
            m_pend   <= '0;
            m_scnt   <= 0;
            m_fcnt_b <= 0;
            m_fcnt_n <= 0;
        end else begin
            if (exp_hz() && m_scnt < MAXC) m_scnt <= m_scnt + 1;
            if ((pcsrce ^ pred_e) && m_fcnt_b < MAXC) m_fcnt_b <= m_fcnt_b + 1;
            if (pcsrce && m_fcnt_n < MAXC) m_fcnt_n <= m_fcnt_n + 1;
            if (!m_busy && mc_issue) begin
                m_busy <= 1'b1;
                m_rd   <= rde;
                if (rde != 0) m_pend[rde] <= 1'b1;
            end else if (m_busy && mc_done) begin
                m_pend[m_rd] <= 1'b0;
                if (mc_issue) begin
                    m_rd <= rde;
                    if (rde != 0) m_pend[rde] <= 1'b1;
                end else begin
                    m_busy <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit h, rb, live;
        live = !rst;
        h    = live && exp_hz();
        rb   = live && (pcsrce ^ pred_e);
        chk("fwda_b",   fwda_b,   live ? exp_fwd(rs1e) : 2'b00);
        chk("fwdb_b",   fwdb_b,   live ? exp_fwd(rs2e) : 2'b00);
        chk("fwda_n",   fwda_n,   live ? exp_fwd(rs1e) : 2'b00);
        chk("fwdb_n",   fwdb_n,   live ? exp_fwd(rs2e) : 2'b00);
        chk("stalld_b", stalld_b, h);
        chk("stallf_b", stallf_b, h);
        chk("flushd_b", flushd_b, rb);
        chk("flushe_b", flushe_b, rb || h);
        chk("stalld_n", stalld_n, h);
        chk("stallf_n", stallf_n, h || (live && branchd));
        chk("flushd_n", flushd_n, live && (pcsrce || branchd));
        chk("flushe_n", flushe_n, (live && pcsrce) || h);
        chk("busy_b",   busy_b,   m_busy);
        chk("busy_n",   busy_n,   m_busy);
        chk("pend_b",   pend_b,   m_pend);
        chk("pend_n",   pend_n,   m_pend);
        chk("scnt_b",   scnt_b,   m_scnt);
        chk("scnt_n",   scnt_n,   m_scnt);
        chk("fcnt_b",   fcnt_b,   m_fcnt_b);
        chk("fcnt_n",   fcnt_n,   m_fcnt_n);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        no_fwd = 0; mcd = 0; regwritee = 0; loade = 0; mc_issue = 0; mc_done = 0;
        regwritem = 0; regwritew = 0; branchd = 0; pcsrce = 0; pred_e = 0;
        rs1d = 0; rs2d = 0; rdd = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
    endtask

    initial begin
        idle();
        // Hazard-looking inputs during reset must not leak to any output.
        loade = 1; rde = 7; rs2d = 7; pcsrce = 1; rs1e = 5; rdm = 5; regwritem = 1;
        #2;
        chk("rst_stalld", stalld_b, 1'b0);
        chk("rst_flushe", flushe_b, 1'b0);
        chk("rst_fwda",   fwda_b,   2'b00);
        chk("rst_pend",   pend_b,   32'h0);
        chk("rst_busy",   busy_b,   1'b0);
        chk("rst_scnt",   scnt_b,   16'h0);
        tick(); tick();
        rst = 0;
        idle();

        rs1e = 5; rdm = 5; regwritem = 1; rdw = 5; regwritew = 1; #1;
        chk("fwd_m_prio", fwda_b, 2'b10);
        tick();
        regwritem = 0; #1;
        chk("fwd_w", fwda_b, 2'b01);
        tick();
        rs1e = 0; #1;
        chk("fwd_x0", fwda_b, 2'b00);
        tick();
        rs2e = 5; no_fwd = 1; #1;
        chk("fwd_disabled", fwdb_b, 2'b00);
        tick();
        idle();

        loade = 1; rde = 7; rs2d = 7; #1;
        chk("lu_stalld", stalld_b, 1'b1);
        chk("lu_stallf", stallf_b, 1'b1);
        chk("lu_flushe", flushe_b, 1'b1);
        chk("lu_flushd", flushd_b, 1'b0);
        tick();
        idle(); #1;
        chk("lu_release", stalld_b, 1'b0);
        chk("lu_scnt",    scnt_b,   16'd1);

        no_fwd = 1; rs1d = 5; rde = 5; regwritee = 1; #1;
        chk("nf_stall", stalld_b, 1'b1);
        tick();
        idle();
        no_fwd = 1; loade = 1; regwritee = 1; #1;
        chk("x0_nostall", stalld_b, 1'b0);
        tick();
        idle();

        mc_issue = 1; rde = 9;
        tick();
        idle(); #1;
        chk("mc_pend9", pend_b, 32'h0000_0200);
        chk("mc_busy",  busy_b, 1'b1);
        rs1d = 9; #1;
        chk("mc_dep_stall", stalld_b, 1'b1);
        tick();
        rs1d = 0; mcd = 1; #1;
        chk("mc_struct_stall", stalld_b, 1'b1);
        tick();
        rs1d = 9; mc_done = 1; #1;
        chk("mc_done_still_stall", stalld_b, 1'b1);
        tick();
        idle(); rs1d = 9; #1;
        chk("mc_released", stalld_b, 1'b0);
        chk("mc_pend_clr", pend_b,   32'h0);
        chk("mc_idle",     busy_b,   1'b0);
        chk("mc_scnt",     scnt_b,   16'd5);
        tick();
        idle();

        mc_issue = 1; rde = 3;
        tick();
        mc_done = 1; mc_issue = 1; rde = 4; #1;
        chk("b2b_pend_old", pend_b, 32'h0000_0008);
        tick();
        idle(); #1;
        chk("b2b_pend_new", pend_b, 32'h0000_0010);
        chk("b2b_busy",     busy_b, 1'b1);
        mc_done = 1; mc_issue = 1; rde = 4;
        tick();
        idle(); #1;
        chk("same_rd_kept", pend_b, 32'h0000_0010);
        mc_done = 1;
        tick();
        idle(); #1;
        chk("b2b_drain", pend_b, 32'h0);
        chk("b2b_idle",  busy_b, 1'b0);

        pcsrce = 1; pred_e = 0; #1;
        chk("mp_flushd_b", flushd_b, 1'b1);
        chk("mp_flushe_b", flushe_b, 1'b1);
        chk("mp_flushd_n", flushd_n, 1'b1);
        tick();
        idle(); #1;
        chk("mp_fcnt_b", fcnt_b, 16'd1);
        pcsrce = 1; pred_e = 1; #1;
        chk("ok_flushd_b", flushd_b, 1'b0);
        chk("ok_flushe_b", flushe_b, 1'b0);
        chk("ok_flushd_n", flushd_n, 1'b1);
        tick();
        idle(); #1;
        chk("ok_fcnt_b", fcnt_b, 16'd1);
        chk("ok_fcnt_n", fcnt_n, 16'd2);
        branchd = 1; #1;
        chk("br_stallf_n", stallf_n, 1'b1);
        chk("br_flushd_n", flushd_n, 1'b1);
        chk("br_stallf_b", stallf_b, 1'b0);
        chk("br_flushd_b", flushd_b, 1'b0);
        tick();
        idle();

        mc_issue = 1; rde = 12;
        tick();
        idle(); #1;
        chk("pre_rst_pend", pend_b, 32'h0000_1000);
        chk("pre_rst_scnt", scnt_b, 16'd5);
        #1 rst = 1;
        #1;
        chk("arst_pend", pend_b, 32'h0);
        chk("arst_busy", busy_b, 1'b0);
        chk("arst_scnt", scnt_b, 16'h0);
        chk("arst_fcnt", fcnt_b, 16'h0);
        tick();
        rst = 0;

        loade = 1; rde = 7; rs2d = 7;
        repeat ((1 << CNT_W) + 5) tick();
        chk("sat_scnt_b", scnt_b, 16'hFFFF);
        chk("sat_scnt_n", scnt_n, 16'hFFFF);
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
